vend_scheduler: RTL

- Sequences one shared dispense/change datapath for NUM_PANEL independent customer panels.
- Each panel owns its own coin-accumulation front end and presents a completed purchase request: item select plus credit.
- The scheduler arbitrates round-robin and checks credit against the item price.
- It then drives the dispenser handshake, emits change as unit pulses, and returns done or reject to the winning panel.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_if.sv | 29 ++
 rtl/vend_rr_arbiter.sv | 36 +++
 rtl/vend_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending scheduler: FSM state encoding,
// default item prices, item-select encoding and a small width helper.
package vend_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    DISP   = 3'd2,
    CHANGE = 3'd3,
    FIN    = 3'd4
  } state_t;

  // Default prices in credit units
  localparam int DEF_PRICE1 = 3;
  localparam int DEF_PRICE2 = 5;

  // Item-select encoding on the sel inputs and on disp_item
  localparam logic SEL_ITEM0 = 1'b0;
  localparam logic SEL_ITEM1 = 1'b1;

  // Width of a panel index; never below one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vend_if.sv
// Panel and dispenser signal bundle for the vending scheduler.
// master = panels/dispenser side, slave = scheduler side.
interface vend_if #(
  parameter int NUM_PANEL = 2,
  parameter int CW        = 4
) ();

  logic [NUM_PANEL-1:0]    req;
  logic [NUM_PANEL-1:0]    sel;
  logic [NUM_PANEL*CW-1:0] credit;
  logic [NUM_PANEL-1:0]    done;
  logic [NUM_PANEL-1:0]    reject;
  logic                    disp_valid;
  logic                    disp_item;
  logic                    disp_ready;
  logic                    chg_pulse;
  logic                    busy;

  modport master (
    output req, sel, credit, disp_ready,
    input  done, reject, disp_valid, disp_item, chg_pulse, busy
  );

  modport slave (
    input  req, sel, credit, disp_ready,
    output done, reject, disp_valid, disp_item, chg_pulse, busy
  );

endinterface

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after the last-served index, wrapping around.
module vend_rr_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_PANEL = 2,
  parameter int IW        = idx_width(NUM_PANEL)
) (
  input  logic [NUM_PANEL-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [NUM_PANEL-1:0] grant,
  output logic [IW-1:0]        idx,
  output logic                 any
);

  int   cand;
  logic found;

  // Scan panels starting one past the last served one; first hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_PANEL; k++) begin
      cand = (int'(last) + k) % NUM_PANEL;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
    any = found;
  end

endmodule

// File: rtl/vend_scheduler.sv
// Shared dispense/change sequencer for NUM_PANEL customer panels.
// Round-robin arbitration, credit check, dispenser handshake, change
// returned as unit pulses, done/reject back to the served panel.
// Optional feature macro: VEND_DISP_TIMEOUT_EN -- when defined, a DISP
// that sees no disp_ready within TIMEOUT cycles refunds the full credit
// as change pulses and ends with reject instead of done.
module vend_scheduler
  import vend_pkg::*;
#(
  parameter int NUM_PANEL = 2,
  parameter int CW        = 4,
  parameter int PRICE1    = DEF_PRICE1,
  parameter int PRICE2    = DEF_PRICE2,
  parameter int TIMEOUT   = 15
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  localparam int IW = idx_width(NUM_PANEL);

  // Parameter sanity checks at elaboration time
  if (NUM_PANEL < 2 || NUM_PANEL > 8) begin : g_bad_num_panel
    $error("vend_scheduler: NUM_PANEL must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("vend_scheduler: TIMEOUT must be at least 1");
  end

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [IW-1:0]   last_reg, last_next;
  logic            sel_reg, sel_next;
  logic [CW-1:0]   credit_reg, credit_next;
  logic [CW-1:0]   chg_reg, chg_next;
  logic [CW-1:0]   price;

  logic [NUM_PANEL-1:0] gnt_onehot;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [CW-1:0]        credit_masked [NUM_PANEL];
  logic [CW-1:0]        credit_gnt;

`ifdef VEND_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          refund_reg, refund_next;
`endif

  vend_rr_arbiter #(
    .NUM_PANEL (NUM_PANEL),
    .IW        (IW)
  ) u_arb (
    .req   (bus.req),
    .last  (last_reg),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Per-panel credit slices gated by the one-hot grant
  for (genvar gi = 0; gi < NUM_PANEL; gi++) begin : g_credit
    assign credit_masked[gi] = gnt_onehot[gi] ? bus.credit[gi*CW +: CW] : '0;
  end

  // OR-combine the gated slices into the granted panel's credit
  always_comb begin
    credit_gnt = '0;
    for (int i = 0; i < NUM_PANEL; i++) begin
      credit_gnt = credit_gnt | credit_masked[i];
    end
  end

  assign price = (sel_reg == SEL_ITEM1) ? CW'(PRICE2) : CW'(PRICE1);

  // State and latched-transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      last_reg   <= IW'(NUM_PANEL - 1);
      sel_reg    <= 1'b0;
      credit_reg <= '0;
      chg_reg    <= '0;
`ifdef VEND_DISP_TIMEOUT_EN
      tmo_reg    <= '0;
      refund_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      last_reg   <= last_next;
      sel_reg    <= sel_next;
      credit_reg <= credit_next;
      chg_reg    <= chg_next;
`ifdef VEND_DISP_TIMEOUT_EN
      tmo_reg    <= tmo_next;
      refund_reg <= refund_next;
`endif
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    last_next      = last_reg;
    sel_next       = sel_reg;
    credit_next    = credit_reg;
    chg_next       = chg_reg;
    bus.done       = '0;
    bus.reject     = '0;
    bus.disp_valid = 1'b0;
    bus.disp_item  = 1'b0;
    bus.chg_pulse  = 1'b0;
    bus.busy       = (state_reg != IDLE);
`ifdef VEND_DISP_TIMEOUT_EN
    tmo_next       = '0;
    refund_next    = refund_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (gnt_any) begin
          idx_next    = gnt_idx;
          sel_next    = |(bus.sel & gnt_onehot);
          credit_next = credit_gnt;
          state_next  = CHECK;
`ifdef VEND_DISP_TIMEOUT_EN
          refund_next = 1'b0;
`endif
        end
      end

      CHECK: begin
        if (credit_reg < price) begin
          bus.reject[idx_reg] = 1'b1;
          last_next           = idx_reg;
          state_next          = IDLE;
        end else begin
          chg_next   = credit_reg - price;
          state_next = DISP;
        end
      end

      DISP: begin
        bus.disp_valid = 1'b1;
        bus.disp_item  = sel_reg;
        if (bus.disp_ready) begin
          state_next = (chg_reg != '0) ? CHANGE : FIN;
        end
`ifdef VEND_DISP_TIMEOUT_EN
        else if (tmo_reg == TW'(TIMEOUT - 1)) begin
          // Dispenser never answered: refund everything and reject
          chg_next    = credit_reg;
          refund_next = 1'b1;
          state_next  = (credit_reg != '0) ? CHANGE : FIN;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
`endif
      end

      CHANGE: begin
        bus.chg_pulse = 1'b1;
        chg_next      = chg_reg - CW'(1);
        if (chg_reg == CW'(1)) begin
          state_next = FIN;
        end
      end

      FIN: begin
`ifdef VEND_DISP_TIMEOUT_EN
        if (refund_reg) begin
          bus.reject[idx_reg] = 1'b1;
        end else begin
          bus.done[idx_reg] = 1'b1;
        end
`else
        bus.done[idx_reg] = 1'b1;
`endif
        last_next  = idx_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
